// File: rtl/wb_uart_arbiter_if.sv
// Bus bundle between the two Wishbone masters, the arbiter and the UART macro slave port.
// Latency: none, wires only.
// Backpressure: carried by the Wishbone ack/err handshake; slave modport is the arbiter, master modport is the environment.
interface wb_uart_arbiter_if;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_adr_i, m0_dat_i;
    logic        m0_ack_o, m0_err_o;
    logic [31:0] m0_dat_o;

    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_adr_i, m1_dat_i;
    logic        m1_ack_o, m1_err_o;
    logic [31:0] m1_dat_o;

    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic        s_ack_i;
    logic [31:0] s_dat_i;

    logic [1:0]  gnt_o;
    logic        timeout_o;

    // Arbiter view: masters and UART responses in, routed bus and status out.
    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
        output m0_ack_o, m0_err_o, m0_dat_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
        output m1_ack_o, m1_err_o, m1_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        input  s_ack_i, s_dat_i,
        output gnt_o, timeout_o
    );

    // Environment view: drives the masters and the UART responses.
    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
        input  m0_ack_o, m0_err_o, m0_dat_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
        input  m1_ack_o, m1_err_o, m1_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        output s_ack_i, s_dat_i,
        input  gnt_o, timeout_o
    );
endinterface

// File: rtl/wb_uart_arbiter.sv
// Round-robin two-master Wishbone arbiter for the UART macro; grant held for a whole cyc. Optional watchdog: ARB_TIMEOUT_EN.
// Latency: one cycle request-to-grant; address/data/ack pass through combinationally while granted.
// Backpressure: the losing master stalls with its request held; with ARB_TIMEOUT_EN a stalled strobe is aborted with err.
module wb_uart_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    wb_uart_arbiter_if.slave bus
);

`ifdef ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ABORT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1} state_t;
`endif

    state_t      state, state_nxt;
    // last_grant doubles as the current owner while BUSY/ABORT
    logic        last_grant, last_grant_nxt;
    logic        req0, req1, busy, hit;
    logic        k_cyc, k_stb, k_we;
    logic [3:0]  k_sel;
    logic [31:0] k_adr, k_dat;

    assign req0  = bus.m0_cyc_i & bus.m0_stb_i;
    assign req1  = bus.m1_cyc_i & bus.m1_stb_i;
    assign busy  = (state == BUSY);

    assign k_cyc = last_grant ? bus.m1_cyc_i : bus.m0_cyc_i;
    assign k_stb = last_grant ? bus.m1_stb_i : bus.m0_stb_i;
    assign k_we  = last_grant ? bus.m1_we_i  : bus.m0_we_i;
    assign k_sel = last_grant ? bus.m1_sel_i : bus.m0_sel_i;
    assign k_adr = last_grant ? bus.m1_adr_i : bus.m0_adr_i;
    assign k_dat = last_grant ? bus.m1_dat_i : bus.m0_dat_i;

    assign bus.gnt_o = (state == IDLE) ? 2'b00 : (last_grant ? 2'b10 : 2'b01);

`ifdef ARB_TIMEOUT_EN
    logic [TO_W-1:0] wd_cnt, wd_cnt_nxt;
    logic            timeout_q;

    // An ack in the limit cycle wins, so the abort needs the ack to be absent
    assign hit = busy & k_stb & ~bus.s_ack_i & (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Watchdog next value: count consecutive unacknowledged strobe cycles, else clear
    always_comb begin
        wd_cnt_nxt = '0;
        if (busy && !hit && k_cyc && k_stb && !bus.s_ack_i) begin
            wd_cnt_nxt = wd_cnt + 1'b1;
        end
    end

    // Watchdog counter and sticky timeout flag
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt <= wd_cnt_nxt;
            if (hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.timeout_o = timeout_q;
`else
    logic unused_cfg;
    assign unused_cfg    = ^{TIMEOUT_CYCLES, TO_W};
    assign hit           = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

    // State and owner registers; m0 wins the first tie after reset
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Next state: round-robin pick in IDLE, hold the grant until the owner drops cyc
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    last_grant_nxt = (req0 && req1) ? ~last_grant : req1;
                    state_nxt      = BUSY;
                end
            end
            BUSY: begin
`ifdef ARB_TIMEOUT_EN
                if (hit) begin
                    state_nxt = ABORT;
                end else
`endif
                if (!k_cyc) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Route the owner's request to the UART and its response back; everything else reads 0
    always_comb begin
        bus.s_cyc_o  = 1'b0;
        bus.s_stb_o  = 1'b0;
        bus.s_we_o   = 1'b0;
        bus.s_sel_o  = 4'h0;
        bus.s_adr_o  = 32'h0;
        bus.s_dat_o  = 32'h0;
        bus.m0_ack_o = 1'b0;
        bus.m0_err_o = 1'b0;
        bus.m0_dat_o = 32'h0;
        bus.m1_ack_o = 1'b0;
        bus.m1_err_o = 1'b0;
        bus.m1_dat_o = 32'h0;
        if (busy) begin
            bus.s_cyc_o = k_cyc & ~hit;
            bus.s_stb_o = k_stb & ~hit;
            bus.s_we_o  = k_we;
            bus.s_sel_o = k_sel;
            bus.s_adr_o = k_adr;
            bus.s_dat_o = k_dat;
            if (last_grant) begin
                bus.m1_ack_o = bus.s_ack_i & k_cyc;
                bus.m1_err_o = hit;
                bus.m1_dat_o = bus.s_dat_i;
            end else begin
                bus.m0_ack_o = bus.s_ack_i & k_cyc;
                bus.m0_err_o = hit;
                bus.m0_dat_o = bus.s_dat_i;
            end
        end
    end

endmodule

// File: doc/wb_uart_arbiter.md
Name: wb_uart_arbiter

Overview:
Two-master Wishbone arbiter that shares the single UART macro slave port. Master 0 is the management core's Wishbone bus; master 1 is a secondary requester, e.g. an LA-driven test master. Round-robin grant, held for a whole bus cycle (cyc), with an optional bus watchdog. Sits between the user-project wrapper ports and the UART macro wrapper.

Parameters:
TIMEOUT_CYCLES, 255, cycles stb may stay unacknowledged before the watchdog aborts (1..2^TO_W-1)
TO_W, 8, watchdog counter width

Ports:
wb_clk_i  in  1  bus clock
wb_rst_n_i  in  1  reset, asynchronous, active-low
m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 cycle/strobe/write
m0_sel_i  in  4  master 0 byte selects
m0_adr_i, m0_dat_i  in  32 each  master 0 address/write data
m0_ack_o, m0_err_o  out  1 each  master 0 acknowledge/error
m0_dat_o  out  32  master 0 read data
m1_* (same seven inputs, three outputs)  master 1, identical widths
s_cyc_o, s_stb_o, s_we_o  out  1 each  to UART macro
s_sel_o  out  4  to UART macro
s_adr_o, s_dat_o  out  32 each  to UART macro
s_ack_i  in  1  from UART macro
s_dat_i  in  32  from UART macro
gnt_o  out  2  one-hot current grant (00 = idle)
timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset (async assert, sync release): state IDLE; gnt_o=00; last_grant=1, so m0 wins the first tie; timeout_o=0; watchdog count=0.
- All outputs are 0 during reset: s_* outputs, m*_ack_o, m*_err_o, m*_dat_o.
- Request: req_k = mk_cyc_i & mk_stb_i.
- IDLE:
  - Neither request -> stay in IDLE.
  - One request -> grant that master.
  - Both requests -> grant the master that is not last_grant.
  - The grant is registered, so there is one cycle of arbitration latency: request seen at edge N, gnt_o and s_cyc_o/s_stb_o valid after edge N+1.
  - On grant, update last_grant and go to BUSY.
- BUSY, granted master k:
  - s_cyc_o = mk_cyc_i; s_stb_o = mk_stb_i; s_we/sel/adr/dat = master k's signals. All combinational pass-through.
  - mk_ack_o = s_ack_i and mk_dat_o = s_dat_i, combinational.
  - Non-granted master: ack=0, err=0, dat=0. It stalls with its request held.
  - Grant persists across back-to-back strobes while mk_cyc_i=1.
  - mk_cyc_i=0 -> s_cyc_o drops the same cycle; next edge goes to IDLE with gnt_o=00.
  - This also holds if cyc drops before any ack; the abandoned transfer generates no ack.
- Fairness: after a cycle ends, a pending request from the other master is granted next even if the same master re-requests immediately.
  - Minimum one IDLE cycle between grants.
- Watchdog, in BUSY:
  - Counts cycles with s_stb_o=1 & s_ack_i=0; clears on ack or when stb is low.
  - Count reaching TIMEOUT_CYCLES -> mk_err_o=1 for exactly one cycle, s_cyc_o/s_stb_o forced 0, timeout_o set.
  - Then go to ABORT for one cycle (s_cyc forced 0, gnt held), then IDLE.
  - An ack arriving in the same cycle the count reaches the limit wins: it is a normal ack with no error.
  - timeout_o is cleared only by reset.
- s_ack_i seen while IDLE or ABORT is ignored and not forwarded.

Optional Feature:
ARB_TIMEOUT_EN
- Defined: watchdog, ABORT state, mk_err_o and timeout_o behave as specified above.
- Undefined: no counter and no ABORT state; m0_err_o, m1_err_o and timeout_o are tied 0; a stalled slave holds the grant indefinitely.

Test Plan:
- m0 write adr=0x3000_0004, dat=0x55, slave acks 2 cycles after stb -> gnt_o=01 one cycle after request; s_dat_o=0x55; m0_ack_o pulses once; gnt_o=00 after m0 cyc drops.
- m0 and m1 both request from reset -> m0 granted first. m0 ends; m0 and m1 re-request together -> m1 granted. Next tie -> m0.
- m1 holds cyc for 4 strobes (read, slave returns 0xA1..0xA4) while m0 requests -> m0 sees no ack during all 4; m1 receives 0xA1..0xA4 in order; m0 granted after m1 drops cyc.
- m0 drops cyc 1 cycle into a transfer, before any ack -> s_cyc_o=0 that cycle; no m0_ack_o; gnt_o=00 next cycle.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> m0_err_o pulses on the 8th stalled cycle; timeout_o=1 stays high; pending m1 granted after ABORT + IDLE.
- wb_rst_n_i asserted mid-BUSY -> all outputs 0 immediately (asynchronous); after release, m0 wins a tie.
